// File: rtl/id_stage_pipe.sv
// ARM instruction-decode stage: 16-entry register file, condition check, control decode and a
// valid/ready output register, optionally backed by a one-entry skid buffer.
module id_stage_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned WB_BYPASS = 1,
    parameter int unsigned SKID      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [3:0]        sr,
    input  logic              hazard,
    input  logic              wb_en_in,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        dest
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [3:0]        dest;
    } bundle_t;

    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rd1, rd2;
    logic [1:0]        mode;
    logic [3:0]        opcode;
    logic              s_bit, is_str;
    logic              fn, fz, fc, fv;
    logic              cond_ok;
    logic              c_wb, c_mr, c_mw, c_b, c_s;
    logic [3:0]        c_exe;
    bundle_t           new_b;
    bundle_t           out_q, out_d, skid_q, skid_d;
    logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic              out_free, accept;

    assign mode    = instr[27:26];
    assign opcode  = instr[24:21];
    assign s_bit   = instr[20];
    assign is_str  = (mode == 2'b01) & ~s_bit;
    assign src1    = instr[19:16];
    assign src2    = is_str ? instr[15:12] :
                     (~instr[25] & ~instr[4]) ? instr[3:0] : 4'd0;
    assign two_src = ~instr[25] | is_str;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (wb_en_in) begin
            rf_q[wb_dest] <= wb_data;
        end
    end

    always_comb begin
        rd1 = rf_q[src1];
        rd2 = rf_q[src2];
        if (WB_BYPASS != 0 && wb_en_in) begin
            if (wb_dest == src1) rd1 = wb_data;
            if (wb_dest == src2) rd2 = wb_data;
        end
    end

    assign {fn, fz, fc, fv} = sr;

    always_comb begin
        cond_ok = 1'b1;
        case (instr[31:28])
            4'h0:    cond_ok = fz;
            4'h1:    cond_ok = ~fz;
            4'h2:    cond_ok = fc;
            4'h3:    cond_ok = ~fc;
            4'h4:    cond_ok = fn;
            4'h5:    cond_ok = ~fn;
            4'h6:    cond_ok = fv;
            4'h7:    cond_ok = ~fv;
            4'h8:    cond_ok = fc & ~fz;
            4'h9:    cond_ok = ~fc | fz;
            4'hA:    cond_ok = (fn == fv);
            4'hB:    cond_ok = (fn != fv);
            4'hC:    cond_ok = ~fz & (fn == fv);
            4'hD:    cond_ok = fz | (fn != fv);
            default: cond_ok = 1'b1;
        endcase
    end

    always_comb begin
        c_wb  = 1'b0;
        c_mr  = 1'b0;
        c_mw  = 1'b0;
        c_b   = 1'b0;
        c_s   = 1'b0;
        c_exe = 4'd0;
        case (mode)
            2'b00: begin
                c_s = s_bit;
                case (opcode)
                    4'b1101: begin c_exe = 4'b0001; c_wb = 1'b1; end
                    4'b1111: begin c_exe = 4'b1001; c_wb = 1'b1; end
                    4'b0100: begin c_exe = 4'b0010; c_wb = 1'b1; end
                    4'b0101: begin c_exe = 4'b0011; c_wb = 1'b1; end
                    4'b0010: begin c_exe = 4'b0100; c_wb = 1'b1; end
                    4'b0110: begin c_exe = 4'b0101; c_wb = 1'b1; end
                    4'b0000: begin c_exe = 4'b0110; c_wb = 1'b1; end
                    4'b1100: begin c_exe = 4'b0111; c_wb = 1'b1; end
                    4'b0001: begin c_exe = 4'b1000; c_wb = 1'b1; end
                    4'b1010: c_exe = 4'b0100;
                    4'b1000: c_exe = 4'b0110;
                    default: ;
                endcase
            end
            2'b01: begin
                c_exe = 4'b0010;
                if (s_bit) begin
                    c_mr = 1'b1;
                    c_wb = 1'b1;
                end else begin
                    c_mw = 1'b1;
                end
            end
            2'b10:   c_b = 1'b1;
            default: ;
        endcase
    end

    // A failed condition still produces a bundle, just with every side effect masked off.
    always_comb begin
        new_b               = '0;
        new_b.val_rn        = rd1;
        new_b.val_rm        = rd2;
        new_b.imm           = instr[25];
        new_b.shift_operand = instr[11:0];
        new_b.signed_imm_24 = instr[23:0];
        new_b.dest          = instr[15:12];
        if (cond_ok) begin
            new_b.wb_en    = c_wb;
            new_b.mem_r_en = c_mr;
            new_b.mem_w_en = c_mw;
            new_b.b        = c_b;
            new_b.s        = c_s;
            new_b.exe_cmd  = c_exe;
        end
    end

    assign out_free = ~out_valid_q | out_ready;
    assign in_ready = ~hazard & ((SKID != 0) ? ~skid_valid_q : out_free);
    assign accept   = in_valid & in_ready;

    // The skid entry only fills while the output is stalled, so it always drains first.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_d       = new_b;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (SKID != 0 && accept) begin
            skid_valid_d = 1'b1;
            skid_d       = new_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign wb_en         = out_q.wb_en;
    assign mem_r_en      = out_q.mem_r_en;
    assign mem_w_en      = out_q.mem_w_en;
    assign b             = out_q.b;
    assign s             = out_q.s;
    assign exe_cmd       = out_q.exe_cmd;
    assign val_rn        = out_q.val_rn;
    assign val_rm        = out_q.val_rm;
    assign imm           = out_q.imm;
    assign shift_operand = out_q.shift_operand;
    assign signed_imm_24 = out_q.signed_imm_24;
    assign dest          = out_q.dest;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: a SKID=0 and a SKID=1 instance share stimulus; each has its own
// scoreboard queue fed by a reference decode model.
module tb_id_stage_pipe;

    localparam int BW = 114;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, hazard, wb_en_in, out_ready;
    logic [31:0] instr;
    logic [3:0]  sr, wb_dest;
    logic [31:0] wb_data;

    logic        in_ready_w [2];
    logic [3:0]  src1_w [2];
    logic [3:0]  src2_w [2];
    logic        two_src_w [2];
    logic        out_valid_w [2];
    logic        wb_en_w [2];
    logic        mem_r_en_w [2];
    logic        mem_w_en_w [2];
    logic        b_w [2];
    logic        s_w [2];
    logic [3:0]  exe_cmd_w [2];
    logic [31:0] val_rn_w [2];
    logic [31:0] val_rm_w [2];
    logic        imm_w [2];
    logic [11:0] shop_w [2];
    logic [23:0] simm_w [2];
    logic [3:0]  dest_w [2];

    logic [BW-1:0] sbq [2][$];
    logic [31:0]   rf_m [16];
    logic [31:0]   itab [14];
    int            acc_cnt [2];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .WB_BYPASS(1), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .instr(instr), .sr(sr), .hazard(hazard), .wb_en_in(wb_en_in), .wb_dest(wb_dest),
        .wb_data(wb_data), .src1(src1_w[0]), .src2(src2_w[0]), .two_src(two_src_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .wb_en(wb_en_w[0]),
        .mem_r_en(mem_r_en_w[0]), .mem_w_en(mem_w_en_w[0]), .b(b_w[0]), .s(s_w[0]),
        .exe_cmd(exe_cmd_w[0]), .val_rn(val_rn_w[0]), .val_rm(val_rm_w[0]), .imm(imm_w[0]),
        .shift_operand(shop_w[0]), .signed_imm_24(simm_w[0]), .dest(dest_w[0])
    );

    id_stage_pipe #(.DATA_W(32), .WB_BYPASS(1), .SKID(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .instr(instr), .sr(sr), .hazard(hazard), .wb_en_in(wb_en_in), .wb_dest(wb_dest),
        .wb_data(wb_data), .src1(src1_w[1]), .src2(src2_w[1]), .two_src(two_src_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .wb_en(wb_en_w[1]),
        .mem_r_en(mem_r_en_w[1]), .mem_w_en(mem_w_en_w[1]), .b(b_w[1]), .s(s_w[1]),
        .exe_cmd(exe_cmd_w[1]), .val_rn(val_rn_w[1]), .val_rm(val_rm_w[1]), .imm(imm_w[1]),
        .shift_operand(shop_w[1]), .signed_imm_24(simm_w[1]), .dest(dest_w[1])
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ctl_of(input int k);
        return {wb_en_w[k], mem_r_en_w[k], mem_w_en_w[k], b_w[k], s_w[k], exe_cmd_w[k]};
    endfunction

    function automatic logic [BW-1:0] got_b(input int k);
        return {ctl_of(k), val_rn_w[k], val_rm_w[k], imm_w[k], shop_w[k], simm_w[k], dest_w[k]};
    endfunction

    // Reference decode: {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}
    function automatic logic [8:0] ctl_m(input logic [31:0] ins);
        logic [3:0] e;
        logic       w, r, m, br, sf;
        {e, w, r, m, br, sf} = '0;
        case (ins[27:26])
            2'b00: begin
                sf = ins[20];
                case (ins[24:21])
                    4'hD: begin e = 4'd1; w = 1'b1; end
                    4'hF: begin e = 4'd9; w = 1'b1; end
                    4'h4: begin e = 4'd2; w = 1'b1; end
                    4'h5: begin e = 4'd3; w = 1'b1; end
                    4'h2: begin e = 4'd4; w = 1'b1; end
                    4'h6: begin e = 4'd5; w = 1'b1; end
                    4'h0: begin e = 4'd6; w = 1'b1; end
                    4'hC: begin e = 4'd7; w = 1'b1; end
                    4'h1: begin e = 4'd8; w = 1'b1; end
                    4'hA: e = 4'd4;
                    4'h8: e = 4'd6;
                    default: ;
                endcase
            end
            2'b01: begin
                e = 4'd2;
                if (ins[20]) begin r = 1'b1; w = 1'b1; end
                else m = 1'b1;
            end
            2'b10: br = 1'b1;
            default: ;
        endcase
        return {w, r, m, br, sf, e};
    endfunction

    function automatic logic cond_m(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] src2_m(input logic [31:0] ins);
        if (ins[27:26] == 2'b01 && !ins[20]) return ins[15:12];
        if (!ins[25] && !ins[4]) return ins[3:0];
        return 4'd0;
    endfunction

    function automatic logic two_src_m(input logic [31:0] ins);
        return !ins[25] || (ins[27:26] == 2'b01 && !ins[20]);
    endfunction

    function automatic logic [BW-1:0] model_bundle(input logic [31:0] ins);
        logic [3:0]  a1, a2;
        logic [31:0] rn, rm;
        logic [8:0]  c;
        a1 = ins[19:16];
        a2 = src2_m(ins);
        rn = rf_m[a1];
        rm = rf_m[a2];
        if (wb_en_in && wb_dest == a1) rn = wb_data;
        if (wb_en_in && wb_dest == a2) rm = wb_data;
        c = cond_m(ins[31:28], sr) ? ctl_m(ins) : 9'd0;
        return {c, rn, rm, ins[25], ins[11:0], ins[23:0], ins[15:12]};
    endfunction

    // Scoreboard: sampled mid-cycle, mirrors the handshakes of the coming rising edge.
    always @(negedge clk) begin
        logic [BW-1:0] exp_b;
        logic          exp_rdy;
        if (!rst) begin
            for (int k = 0; k < 2; k++) sbq[k].delete();
            for (int r = 0; r < 16; r++) rf_m[r] = '0;
        end else begin
            exp_b = model_bundle(instr);
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("src1[%0d]", k), src1_w[k], instr[19:16]);
                check_eq($sformatf("src2[%0d]", k), src2_w[k], src2_m(instr));
                check_eq($sformatf("two_src[%0d]", k), two_src_w[k], two_src_m(instr));
                check_eq($sformatf("out_valid[%0d]", k), out_valid_w[k], sbq[k].size() != 0);
                if (k == 0) exp_rdy = !hazard && (sbq[k].size() == 0 || out_ready);
                else        exp_rdy = !hazard && (sbq[k].size() < 2);
                check_eq($sformatf("in_ready[%0d]", k), in_ready_w[k], exp_rdy);
                if (out_valid_w[k] && out_ready) begin
                    if (sbq[k].size() == 0)
                        check_eq($sformatf("spurious[%0d]", k), out_valid_w[k], 1'b0);
                    else
                        check_eq($sformatf("bundle[%0d]", k), got_b(k), sbq[k].pop_front());
                end
                if (flush) begin
                    sbq[k].delete();
                end else if (in_valid && in_ready_w[k]) begin
                    sbq[k].push_back(exp_b);
                    acc_cnt[k]++;
                end
            end
            if (wb_en_in) rf_m[wb_dest] = wb_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        hazard    = 1'b0;
        wb_en_in  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        accepted, done;
        logic [31:0] ins;
        int          a0;
        itab = '{32'hE3A01005, 32'hE0432001, 32'hE1530002, 32'hE5912004, 32'hE5823008,
                 32'hEA000010, 32'hE0811312, 32'hE1E05004, 32'hE0100003, 32'hE1844005,
                 32'hE0245006, 32'hE0A11002, 32'hE0C22003, 32'hE1130004};
        acc_cnt = '{0, 0};
        rst = 1'b0;
        idle();
        instr = '0; sr = '0; wb_dest = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_out_valid", out_valid_w[k], 1'b0);
            check_eq("rst_bundle", got_b(k), '0);
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) check_eq("release_in_ready", in_ready_w[k], !hazard);

        // write R3 then read it
        wb_en_in = 1'b1; wb_dest = 4'd3; wb_data = 32'h1234;
        tick();
        wb_en_in = 1'b0; in_valid = 1'b1; instr = 32'hE0831002;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq("add_latency", out_valid_w[k], 1'b1);
            check_eq("add_val_rn", val_rn_w[k], 32'h1234);
            check_eq("add_ctl", ctl_of(k), 9'b100000010);
        end

        // same-cycle write and read uses the bypass
        wb_en_in = 1'b1; wb_data = 32'h5555;
        tick();
        wb_data = 32'h1234; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; wb_en_in = 1'b0;
        for (int k = 0; k < 2; k++) check_eq("bypass_val_rn", val_rn_w[k], 32'h1234);

        // EQ with Z=0 fails
        instr = 32'h00831002; sr = 4'b0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq("condfail_valid", out_valid_w[k], 1'b1);
            check_eq("condfail_ctl", ctl_of(k), 9'd0);
            check_eq("condfail_dest", dest_w[k], 4'd1);
        end
        repeat (2) tick();

        // backpressure: three-instruction stream against a stalled output
        a0 = acc_cnt[1];
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'hE2811005; tick();
        instr = 32'hE5912004; tick();
        instr = 32'hE5823008; tick();
        check_eq("bp_held", acc_cnt[1] - a0, 2);
        check_eq("bp_in_ready", in_ready_w[1], 1'b0);
        check_eq("bp_out_valid", out_valid_w[1], 1'b1);
        out_ready = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 6 && !done; t++) begin
            accepted = in_ready_w[1];
            tick();
            if (accepted) done = 1'b1;
        end
        in_valid = 1'b0;
        check_eq("bp_third_accept", done, 1'b1);
        check_eq("bp_total", acc_cnt[1] - a0, 3);
        repeat (3) tick();

        // hazard bubble
        in_valid = 1'b1; instr = 32'hE0432001;
        tick();
        hazard = 1'b1; instr = 32'hE1E05004;
        tick();
        hazard = 1'b0;
        for (int k = 0; k < 2; k++) check_eq("hazard_bubble", out_valid_w[k], 1'b0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq("hazard_follow", out_valid_w[k], 1'b1);
            check_eq("hazard_dest", dest_w[k], 4'd5);
        end
        repeat (2) tick();

        // flush with a full skid, plus a register write in the flush cycle
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'hE0811312; tick();
        instr = 32'hE0245006; tick();
        flush = 1'b1; hazard = 1'b1; instr = 32'hE1844005;
        wb_en_in = 1'b1; wb_dest = 4'd7; wb_data = 32'hBEEF;
        tick();
        idle();
        for (int k = 0; k < 2; k++) check_eq("flush_valid", out_valid_w[k], 1'b0);
        for (int t = 0; t < 3; t++) begin
            tick();
            check_eq("flush_no_stale", out_valid_w[1], 1'b0);
        end
        // an accept in the flush cycle is dropped
        flush = 1'b1; in_valid = 1'b1; instr = 32'hE0100003;
        tick();
        idle();
        for (int k = 0; k < 2; k++) check_eq("flush_drop", out_valid_w[k], 1'b0);
        in_valid = 1'b1; instr = 32'hE0871000;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) check_eq("flush_wb_kept", val_rn_w[k], 32'hBEEF);
        repeat (2) tick();

        // randomised traffic
        for (int t = 0; t < 300; t++) begin
            ins = itab[$urandom_range(13, 0)];
            if ($urandom_range(1, 0) == 1) ins[31:28] = 4'($urandom_range(15, 0));
            instr     = ins;
            in_valid  = ($urandom_range(3, 0) != 0);
            sr        = 4'($urandom_range(15, 0));
            hazard    = ($urandom_range(4, 0) == 0);
            out_ready = ($urandom_range(2, 0) != 0);
            flush     = ($urandom_range(24, 0) == 0);
            wb_en_in  = ($urandom_range(1, 0) == 1);
            wb_dest   = 4'($urandom_range(15, 0));
            wb_data   = $urandom;
            tick();
        end
        idle();
        repeat (3) tick();

        // reset in the middle of a stall
        wb_en_in = 1'b1; wb_dest = 4'd3; wb_data = 32'hCAFE;
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hE0432001;
        tick();
        wb_en_in = 1'b0; instr = 32'hE0811312;
        tick();
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("midrst_valid", out_valid_w[k], 1'b0);
            check_eq("midrst_bundle", got_b(k), '0);
        end
        tick();
        rst = 1'b1;
        idle();
        in_valid = 1'b1; instr = 32'hE0831002;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq("postrst_valid", out_valid_w[k], 1'b1);
            check_eq("postrst_val_rn", val_rn_w[k], 32'h0);
        end

        // drain and confirm nothing is left outstanding
        idle();
        for (int t = 0; t < 20 && (sbq[0].size() != 0 || sbq[1].size() != 0); t++) tick();
        tick();
        check_eq("drain0", sbq[0].size(), 0);
        check_eq("drain1", sbq[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
